rtc_time_editor: RTL and testbench
==================================

RTC_TIME_EDITOR -- requirements
Module: rtc_time_editor

Interface
REQ-001 Parameter BLINK_DIV, default 12_500_000, clk cycles per blink half-period.
REQ-002 Parameter ACK_TIMEOUT, default 1_000_000, maximum clk cycles to wait for wr_ack in COMMIT.
REQ-003 Port clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Ports key_mode_p, key_hour_p, key_min_p, key_sec_p, input, 1 each, one-cycle debounced press pulses.
REQ-006 Ports read_hour, read_minute, read_second, input, 8 each, BCD time from the RTC reader.
REQ-007 Ports write_hour, write_minute, write_second, output, 8 each, BCD time to be written to the RTC.
REQ-008 Port wr_req, output, 1, write request to the RTC engine; level, held until acknowledged or timed out.
REQ-009 Port wr_ack, input, 1, one-cycle completion pulse from the RTC engine.
REQ-010 Port wr_err, output, 1, one-cycle pulse on ACK_TIMEOUT expiry.
REQ-011 Port editing, output, 1, high in EDIT_INC and EDIT_DEC.
REQ-012 Port blink, output, 1, display blank/show toggle for edit mode.
REQ-013 Port disp_bcd, output, 24, {hour,minute,second} BCD for the 7-segment driver.

Function
REQ-014 The FSM SHALL have states IDLE, EDIT_INC, EDIT_DEC, COMMIT.
REQ-015 IDLE + key_mode_p SHALL load write_* from read_* (normalised per REQ-021) and enter EDIT_INC.
REQ-016 EDIT_INC + key_mode_p SHALL enter EDIT_DEC; EDIT_DEC + key_mode_p SHALL enter COMMIT and assert wr_req the next cycle.
REQ-017 In COMMIT, wr_ack SHALL deassert wr_req and return to IDLE in the same edge; all key pulses SHALL be ignored in COMMIT.
REQ-018 A COMMIT wait counter SHALL count from 0; at ACK_TIMEOUT-1 without wr_ack the block SHALL drop wr_req, pulse wr_err for one cycle, and return to IDLE.
REQ-019 In EDIT_INC, key_hour_p/key_min_p/key_sec_p SHALL increment the field in BCD: hour 23->00, minute/second 59->00, units 9->0 with tens+1.
REQ-020 In EDIT_DEC the same keys SHALL decrement: hour 00->23, minute/second 00->59, units 0->9 with tens-1.
REQ-021 On load, hour SHALL be masked to [5:0] and minute/second to [6:0], with bit 7 (CH) cleared. A field with a units digit >9 or a value above its maximum SHALL load as 00.
REQ-022 Simultaneous pulses SHALL resolve by priority mode > hour > minute > second; exactly one action per cycle.
REQ-023 Field updates SHALL be visible on write_* one cycle after the key pulse, with no combinational key-to-output path.
REQ-024 write_second[7] SHALL always be 0 so a commit never halts the oscillator.
REQ-025 Key pulses in IDLE other than key_mode_p SHALL have no effect.
REQ-026 disp_bcd SHALL equal {write_hour,write_minute,write_second} in edit states and {read_hour,read_minute,read_second} in IDLE/COMMIT; it is registered, one cycle latency.
REQ-027 On entry to EDIT_INC the blink counter SHALL clear and blink SHALL be 1. Blink SHALL toggle each time the counter reaches BLINK_DIV-1, after which the counter wraps to 0.
REQ-028 blink SHALL be held at 1 across the EDIT_INC->EDIT_DEC transition, with the counter continuing. Outside the edit states blink SHALL be 0 and the counter held at 0.
REQ-029 A wr_ack outside COMMIT SHALL be ignored.

Reset
REQ-030 With rst_n low at a clk edge, state SHALL become IDLE and wr_req, wr_err, editing and blink SHALL become 0.
REQ-031 Under the same reset, write_* SHALL become 8'h00, disp_bcd 24'h0, and both counters 0.
REQ-032 Reset asserted mid-COMMIT SHALL drop wr_req on that edge, with no wr_err pulse.

Verification
REQ-033 Increment wrap: read=23:59:59, then mode, hour, min, sec pulses -> write=00:00:00, editing=1.
REQ-034 Decrement wrap: load 00:00:00, then mode twice, hour, min, sec -> write=23:59:59; then mode -> wr_req=1 next cycle; wr_ack -> wr_req=0, state IDLE.
REQ-035 Timeout: BLINK_DIV=4, ACK_TIMEOUT=8, no wr_ack -> wr_req high exactly 8 cycles, wr_err single pulse, then IDLE.
REQ-036 Blink and priority: BLINK_DIV=4, editing -> blink toggles every 4 cycles. Simultaneous hour+sec pulses -> only hour changes.
REQ-037 Normalisation: read_second=8'h85 (CH set, 05) -> write_second=8'h05. read_minute=8'h6A -> write_minute=8'h00.
REQ-038 Reset in EDIT_DEC with write=12:34:56 -> next cycle all outputs 0, IDLE; a subsequent wr_ack has no effect.

Source files
------------

// File: rtl/rtc_time_editor.sv
// -----------------------------------------------------------------------------
// rtc_time_editor
//
// Lets a user edit the RTC time with four push-buttons and commit it back to
// the RTC write engine.
//
//   IDLE     -> mode: snapshot (normalised) read_* into write_*, go EDIT_INC
//   EDIT_INC -> hour/min/sec keys increment the field; mode -> EDIT_DEC
//   EDIT_DEC -> hour/min/sec keys decrement the field; mode -> COMMIT
//   COMMIT   -> wr_req held until wr_ack (-> IDLE) or the wait times out
//               (wr_err pulse, -> IDLE). Keys are ignored here.
//
// Ports
//   clk, rst_n                      system clock, synchronous active-low reset
//   key_mode_p/hour_p/min_p/sec_p   one-cycle debounced key pulses
//   read_hour/minute/second [7:0]   BCD time from the RTC reader
//   write_hour/minute/second [7:0]  BCD time to be written to the RTC
//   wr_req                          write request, level until ack/timeout
//   wr_ack                          one-cycle completion pulse
//   wr_err                          one-cycle pulse when the ack wait expires
//   editing                         high in EDIT_INC / EDIT_DEC
//   blink                           display blank/show toggle while editing
//   disp_bcd [23:0]                 registered {hour,minute,second} for display
// -----------------------------------------------------------------------------
module rtc_time_editor #(
  parameter int BLINK_DIV   = 12_500_000,
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_p,
  input  logic        key_hour_p,
  input  logic        key_min_p,
  input  logic        key_sec_p,
  input  logic [7:0]  read_hour,
  input  logic [7:0]  read_minute,
  input  logic [7:0]  read_second,
  output logic [7:0]  write_hour,
  output logic [7:0]  write_minute,
  output logic [7:0]  write_second,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic        wr_err,
  output logic        editing,
  output logic        blink,
  output logic [23:0] disp_bcd
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EDIT_INC, EDIT_DEC, COMMIT} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_HOUR, SEL_MIN, SEL_SEC} sel_t;

  state_t             state, state_next;
  sel_t               sel;
  logic               load_en;
  logic               timeout;
  logic [BLINK_W-1:0] blink_cnt;
  logic [ACK_W-1:0]   ack_cnt;

  // ---------------------------------------------------------------------------
  // BCD helpers. Fields are always normalised on load, so only valid BCD
  // reaches the inc/dec helpers.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v)           r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'h00)           r = max_v;
    else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
    else                      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Hour keeps bits [5:0]; an invalid units digit or a value past 23 loads 00.
  function automatic logic [7:0] norm_hour(input logic [7:0] raw);
    logic [7:0] v;
    v = {2'b00, raw[5:0]};
    if (v[3:0] > 4'd9 || v > 8'h23) v = 8'h00;
    return v;
  endfunction

  // Minute/second keep bits [6:0]; bit 7 (CH on the seconds register) is
  // dropped so a commit never halts the oscillator.
  function automatic logic [7:0] norm_min_sec(input logic [7:0] raw);
    logic [7:0] v;
    v = {1'b0, raw[6:0]};
    if (v[3:0] > 4'd9 || v > 8'h59) v = 8'h00;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: rst_n is sampled only on the clock edge (synchronous reset), and all
  // sequential state uses non-blocking assignments so every register sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and key decode. Priority mode > hour > minute > second gives
  // exactly one action per cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    sel        = SEL_NONE;
    load_en    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (key_mode_p) begin
          state_next = EDIT_INC;
          load_en    = 1'b1;
        end
      end
      EDIT_INC, EDIT_DEC: begin
        if (key_mode_p)      state_next = (state == EDIT_INC) ? EDIT_DEC : COMMIT;
        else if (key_hour_p) sel = SEL_HOUR;
        else if (key_min_p)  sel = SEL_MIN;
        else if (key_sec_p)  sel = SEL_SEC;
      end
      COMMIT: begin
        // An ack arriving on the last wait cycle still counts as success.
        if (wr_ack) begin
          state_next = IDLE;
        end else if (ack_cnt == ACK_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign editing = (state == EDIT_INC) || (state == EDIT_DEC);

  // ---------------------------------------------------------------------------
  // Editable time fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_hour   <= 8'h00;
      write_minute <= 8'h00;
      write_second <= 8'h00;
    end else if (load_en) begin
      write_hour   <= norm_hour(read_hour);
      write_minute <= norm_min_sec(read_minute);
      write_second <= norm_min_sec(read_second);
    end else begin
      case (sel)
        SEL_HOUR: write_hour   <= (state == EDIT_DEC) ? bcd_dec(write_hour, 8'h23)
                                                      : bcd_inc(write_hour, 8'h23);
        SEL_MIN:  write_minute <= (state == EDIT_DEC) ? bcd_dec(write_minute, 8'h59)
                                                      : bcd_inc(write_minute, 8'h59);
        SEL_SEC:  write_second <= (state == EDIT_DEC) ? bcd_dec(write_second, 8'h59)
                                                      : bcd_inc(write_second, 8'h59);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Commit handshake: wr_req is high exactly while in COMMIT; the wait counter
  // restarts from 0 on every entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_req  <= 1'b0;
      wr_err  <= 1'b0;
      ack_cnt <= '0;
    end else begin
      wr_req  <= (state_next == COMMIT);
      wr_err  <= timeout;
      ack_cnt <= (state == COMMIT && state_next == COMMIT) ? ack_cnt + 1'b1 : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink generator. Restarts showing on edit entry, is forced to "show" on the
  // INC->DEC step without disturbing the counter phase, and is idle outside
  // the edit states.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state_next != EDIT_INC && state_next != EDIT_DEC) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state == IDLE) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      if (state == EDIT_INC && state_next == EDIT_DEC) blink <= 1'b1;
      else if (blink_cnt == BLINK_LAST)                blink <= ~blink;
    end
  end

  // ---------------------------------------------------------------------------
  // Display source: the edited value while editing, the live RTC otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n)       disp_bcd <= 24'h0;
    else if (editing) disp_bcd <= {write_hour, write_minute, write_second};
    else              disp_bcd <= {read_hour, read_minute, read_second};
  end

endmodule

// File: tb/tb_rtc_time_editor.sv
// -----------------------------------------------------------------------------
// tb_rtc_time_editor
//
// Directed bench for rtc_time_editor with BLINK_DIV=4, ACK_TIMEOUT=8.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the
// edge that should have produced them.
// -----------------------------------------------------------------------------
module tb_rtc_time_editor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode_p, key_hour_p, key_min_p, key_sec_p;
  logic [7:0]  read_hour, read_minute, read_second;
  logic [7:0]  write_hour, write_minute, write_second;
  logic        wr_req, wr_ack, wr_err, editing, blink;
  logic [23:0] disp_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_time_editor #(.BLINK_DIV(4), .ACK_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_mode_p   (key_mode_p),
    .key_hour_p   (key_hour_p),
    .key_min_p    (key_min_p),
    .key_sec_p    (key_sec_p),
    .read_hour    (read_hour),
    .read_minute  (read_minute),
    .read_second  (read_second),
    .write_hour   (write_hour),
    .write_minute (write_minute),
    .write_second (write_second),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .editing      (editing),
    .blink        (blink),
    .disp_bcd     (disp_bcd)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic h, input logic mi, input logic s);
    key_mode_p = m;
    key_hour_p = h;
    key_min_p  = mi;
    key_sec_p  = s;
    step();
    key_mode_p = 1'b0;
    key_hour_p = 1'b0;
    key_min_p  = 1'b0;
    key_sec_p  = 1'b0;
  endtask

  task automatic ack_pulse();
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
  endtask

  task automatic set_read(input logic [23:0] t);
    {read_hour, read_minute, read_second} = t;
  endtask

  function automatic logic [23:0] wr_time();
    return {write_hour, write_minute, write_second};
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (wr_time() !== 24'h000000) begin
      n_fail++; $display("FAIL reset_write: got %h expected 000000", wr_time());
    end
    n_checks++;
    if (disp_bcd !== 24'h000000) begin
      n_fail++; $display("FAIL reset_disp: got %h expected 000000", disp_bcd);
    end
    n_checks++;
    if ({wr_req, wr_err, editing, blink} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {wr_req, wr_err, editing, blink});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_inc_wrap();
    set_read(24'h235959);
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h235959 || editing !== 1'b1 || blink !== 1'b1) begin
      n_fail++; $display("FAIL inc_load: got %h ed=%b bl=%b expected 235959 ed=1 bl=1", wr_time(), editing, blink);
    end
    press(0, 1, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h005959) begin
      n_fail++; $display("FAIL inc_hour_wrap: got %h expected 005959", wr_time());
    end
    press(0, 0, 1, 0);
    n_checks++;
    if (wr_time() !== 24'h000059) begin
      n_fail++; $display("FAIL inc_min_wrap: got %h expected 000059", wr_time());
    end
    press(0, 0, 0, 1);
    n_checks++;
    if (wr_time() !== 24'h000000 || editing !== 1'b1) begin
      n_fail++; $display("FAIL inc_sec_wrap: got %h ed=%b expected 000000 ed=1", wr_time(), editing);
    end
    step();
    n_checks++;
    if (disp_bcd !== 24'h000000) begin
      n_fail++; $display("FAIL inc_disp_edit: got %h expected 000000", disp_bcd);
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_req !== 1'b1 || editing !== 1'b0) begin
      n_fail++; $display("FAIL inc_commit_req: got req=%b ed=%b expected req=1 ed=0", wr_req, editing);
    end
    ack_pulse();
    n_checks++;
    if (wr_req !== 1'b0 || disp_bcd !== 24'h235959) begin
      n_fail++; $display("FAIL inc_ack_idle: got req=%b disp=%h expected req=0 disp=235959", wr_req, disp_bcd);
    end
    press(0, 1, 1, 1);
    n_checks++;
    if (wr_time() !== 24'h000000 || editing !== 1'b0) begin
      n_fail++; $display("FAIL idle_keys_ignored: got %h ed=%b expected 000000 ed=0", wr_time(), editing);
    end
  endtask

  task automatic test_dec_wrap();
    set_read(24'h000000);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h000000 || editing !== 1'b1 || blink !== 1'b1) begin
      n_fail++; $display("FAIL dec_enter: got %h ed=%b bl=%b expected 000000 ed=1 bl=1", wr_time(), editing, blink);
    end
    press(0, 1, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h230000) begin
      n_fail++; $display("FAIL dec_hour_wrap: got %h expected 230000", wr_time());
    end
    press(0, 0, 1, 0);
    n_checks++;
    if (wr_time() !== 24'h235900) begin
      n_fail++; $display("FAIL dec_min_wrap: got %h expected 235900", wr_time());
    end
    press(0, 0, 0, 1);
    n_checks++;
    if (wr_time() !== 24'h235959) begin
      n_fail++; $display("FAIL dec_sec_wrap: got %h expected 235959", wr_time());
    end
    press(1, 0, 0, 0);
    n_checks++;
    if ({wr_req, wr_err, editing, blink} !== 4'b1000) begin
      n_fail++; $display("FAIL dec_commit: got %b expected 1000", {wr_req, wr_err, editing, blink});
    end
    press(0, 1, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h235959 || wr_req !== 1'b1) begin
      n_fail++; $display("FAIL commit_keys_ignored: got %h req=%b expected 235959 req=1", wr_time(), wr_req);
    end
    ack_pulse();
    n_checks++;
    if ({wr_req, wr_err, editing} !== 3'b000) begin
      n_fail++; $display("FAIL dec_ack: got %b expected 000", {wr_req, wr_err, editing});
    end
    ack_pulse();
    n_checks++;
    if ({wr_req, wr_err, editing} !== 3'b000 || wr_time() !== 24'h235959) begin
      n_fail++; $display("FAIL stray_ack: got %b %h expected 000 235959", {wr_req, wr_err, editing}, wr_time());
    end
  endtask

  task automatic test_timeout();
    int hi;
    int err_early;
    hi = 0;
    err_early = 0;
    set_read(24'h010203);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    if (wr_req) hi++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!wr_req) break;
      hi++;
      if (wr_err) err_early++;
    end
    n_checks++;
    if (hi !== 8) begin
      n_fail++; $display("FAIL timeout_req_len: got %0d cycles expected 8", hi);
    end
    n_checks++;
    if (wr_err !== 1'b1 || err_early !== 0) begin
      n_fail++; $display("FAIL timeout_err: got err=%b early=%0d expected err=1 early=0", wr_err, err_early);
    end
    step();
    n_checks++;
    if ({wr_req, wr_err, editing} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: got %b expected 000", {wr_req, wr_err, editing});
    end
  endtask

  task automatic test_blink_priority();
    logic exp_b;
    set_read(24'h123456);
    press(1, 0, 0, 0);
    n_checks++;
    if (blink !== 1'b1) begin
      n_fail++; $display("FAIL blink_k0: got %b expected 1", blink);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_b = (k < 4);
      n_checks++;
      if (blink !== exp_b) begin
        n_fail++; $display("FAIL blink_k%0d: got %b expected %b", k, blink, exp_b);
      end
    end
    press(1, 0, 0, 0);
    n_checks++;
    if (blink !== 1'b1) begin
      n_fail++; $display("FAIL blink_hold_dec: got %b expected 1", blink);
    end
    step();
    n_checks++;
    if (blink !== 1'b1) begin
      n_fail++; $display("FAIL blink_cont_a: got %b expected 1", blink);
    end
    step();
    n_checks++;
    if (blink !== 1'b0) begin
      n_fail++; $display("FAIL blink_cont_b: got %b expected 0", blink);
    end
    press(0, 1, 0, 1);
    n_checks++;
    if (wr_time() !== 24'h113456) begin
      n_fail++; $display("FAIL prio_hour_sec: got %h expected 113456", wr_time());
    end
    press(0, 0, 1, 1);
    n_checks++;
    if (wr_time() !== 24'h113356) begin
      n_fail++; $display("FAIL prio_min_sec: got %h expected 113356", wr_time());
    end
    press(1, 1, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h113356 || wr_req !== 1'b1) begin
      n_fail++; $display("FAIL prio_mode_hour: got %h req=%b expected 113356 req=1", wr_time(), wr_req);
    end
    ack_pulse();
  endtask

  task automatic test_normalise();
    set_read({8'hC7, 8'h6A, 8'h85});
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h070005) begin
      n_fail++; $display("FAIL norm_a: got %h expected 070005", wr_time());
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    ack_pulse();
    set_read({8'h24, 8'hD9, 8'hE0});
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h005900) begin
      n_fail++; $display("FAIL norm_b: got %h expected 005900", wr_time());
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    ack_pulse();
    step();
    n_checks++;
    if (disp_bcd !== 24'h24D9E0) begin
      n_fail++; $display("FAIL idle_disp_read: got %h expected 24d9e0", disp_bcd);
    end
  endtask

  task automatic test_reset_mid();
    int err_seen;
    err_seen = 0;
    set_read(24'h123456);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_time() !== 24'h123456 || editing !== 1'b1) begin
      n_fail++; $display("FAIL rst_dec_pre: got %h ed=%b expected 123456 ed=1", wr_time(), editing);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (wr_time() !== 24'h000000 || disp_bcd !== 24'h000000 ||
        {wr_req, wr_err, editing, blink} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_dec: got %h %h %b expected 000000 000000 0000",
                         wr_time(), disp_bcd, {wr_req, wr_err, editing, blink});
    end
    rst_n = 1'b1;
    ack_pulse();
    n_checks++;
    if ({wr_req, wr_err, editing} !== 3'b000 || wr_time() !== 24'h000000) begin
      n_fail++; $display("FAIL rst_ack_ignored: got %b %h expected 000 000000", {wr_req, wr_err, editing}, wr_time());
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_checks++;
    if (wr_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_commit_pre: got req=%b expected 1", wr_req);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (wr_req !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_commit: got req=%b err=%b expected 0 0", wr_req, wr_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wr_err || wr_req) err_seen++;
    end
    n_checks++;
    if (err_seen !== 0) begin
      n_fail++; $display("FAIL rst_commit_after: got %0d active cycles expected 0", err_seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    key_mode_p = 1'b0;
    key_hour_p = 1'b0;
    key_min_p  = 1'b0;
    key_sec_p  = 1'b0;
    wr_ack     = 1'b0;
    set_read(24'h000000);
    test_reset();
    test_inc_wrap();
    test_dec_wrap();
    test_timeout();
    test_blink_priority();
    test_normalise();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
